// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment display driver
// Hex glyph ROM, double-buffered load, leading-zero suppression, dead-time anti-ghosting.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lz_suppress,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_tick
);

  localparam int                  PRE_W    = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_DEAD = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]      prescaler_q, prescaler_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [4*N_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*N_DIGITS-1:0] disp_value_q, disp_value_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [N_DIGITS-1:0]   suppressed;
  logic                  lz_run;
  logic [7:0]            glyph;
  logic                  dark;

  function automatic logic [6:0] glyph_of(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  assign slot_end  = en && (prescaler_q == PRE_LAST);
  assign frame_end = slot_end && (digit_idx_q == IDX_LAST);

  // Leading zeros: a digit stays dark until a higher digit shows something.
  always_comb begin
    suppressed = '0;
    lz_run     = lz_suppress;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if ((disp_value_q[4*i +: 4] != 4'h0) || disp_dp_q[i]) lz_run = 1'b0;
      suppressed[i] = lz_run;
    end
  end

  always_comb begin
    prescaler_d = prescaler_q;
    digit_idx_d = digit_idx_q;
    if (en) begin
      if (slot_end) begin
        prescaler_d = '0;
        digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
      end else begin
        prescaler_d = prescaler_q + PRE_W'(1);
      end
    end
  end

  // Transfer reads the old pending contents; a coincident load refills pending for next frame.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (frame_end && pend_valid_q) begin
      disp_value_d = pend_value_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    glyph        = {glyph_of(disp_value_q[{digit_idx_q, 2'b00} +: 4]), disp_dp_q[digit_idx_q]};
    dark         = disp_blank_q[digit_idx_q] | suppressed[digit_idx_q];
    frame_tick_d = frame_end;
    seg_d        = SEG_OFF;
    an_d         = AN_OFF;
    if (en && (prescaler_q >= PRE_DEAD)) begin
      an_d  = (N_DIGITS'(1) << digit_idx_q) ^ AN_OFF;
      seg_d = (dark ? 8'h00 : glyph) ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      digit_idx_q  <= '0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_idx_q  <= digit_idx_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
// Reference model tracks elapsed enabled cycles and derives slot/digit arithmetically.
module tb_seg7_scan_driver;

  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(DIV), .DEAD_CYCLES(DEAD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp(dp), .blank(blank),
    .lz_suppress(lz), .seg(seg), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int          t;
  int          m_pre, m_idx;
  logic        m_dark, m_lead, m_pv;
  logic [15:0] m_pend_v, m_disp_v;
  logic [3:0]  m_pend_dp, m_pend_bl, m_disp_dp, m_disp_bl;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic [1:0]  e_idx;
  logic        e_ft;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_pv = 0;
      m_pend_v = 0; m_pend_dp = 0; m_pend_bl = 0;
      m_disp_v = 0; m_disp_dp = 0; m_disp_bl = 0;
      e_seg = 8'hFF; e_an = 4'hF; e_ft = 0; e_idx = 0;
    end else begin
      m_pre = t % DIV;
      m_idx = (t / DIV) % N;
      e_seg = 8'hFF;
      e_an  = 4'hF;
      if (en && m_pre >= DEAD) begin
        m_dark = m_disp_bl[m_idx];
        if (lz && m_idx != 0) begin
          m_lead = 1;
          for (int k = m_idx; k < N; k++)
            if (m_disp_v[4*k +: 4] != 0 || m_disp_dp[k]) m_lead = 0;
          if (m_lead) m_dark = 1;
        end
        e_an = ~(4'b0001 << m_idx);
        if (!m_dark) e_seg = ~{glyph[m_disp_v[4*m_idx +: 4]], m_disp_dp[m_idx]};
      end
      e_ft = en && (m_pre == DIV - 1) && (m_idx == N - 1);
      if (e_ft && m_pv) begin
        m_disp_v = m_pend_v; m_disp_dp = m_pend_dp; m_disp_bl = m_pend_bl; m_pv = 0;
      end
      if (load) begin
        m_pend_v = value; m_pend_dp = dp; m_pend_bl = blank; m_pv = 1;
      end
      if (en) t++;
      e_idx = 2'((t / DIV) % N);
    end
  end

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp("model_seg", {24'h0, seg}, {24'h0, e_seg});
    cmp("model_an", {28'h0, an}, {28'h0, e_an});
    cmp("model_idx", {30'h0, digit_idx}, {30'h0, e_idx});
    cmp("model_ft", {31'h0, frame_tick}, {31'h0, e_ft});
  endtask

  task automatic wait_lit(input int d);
    int k = 0;
    while (an !== ~(4'b0001 << d) && k < 64) begin
      tick();
      k++;
    end
    cmp("wait_lit_timeout", {31'h0, (k < 64)}, 32'h1);
  endtask

  task automatic wait_ft();
    int k = 0;
    while (frame_tick !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    cmp("wait_ft_timeout", {31'h0, (k < 64)}, 32'h1);
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    // reset state
    repeat (3) @(negedge clk);
    cmp("rst_seg", {24'h0, seg}, 32'hFF);
    cmp("rst_an", {28'h0, an}, 32'hF);
    cmp("rst_idx", {30'h0, digit_idx}, 32'h0);
    cmp("rst_ft", {31'h0, frame_tick}, 32'h0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    cmp("dead_seg", {24'h0, seg}, 32'hFF);
    cmp("dead_an", {28'h0, an}, 32'hF);
    wait_lit(0);
    cmp("d0_zero", {24'h0, seg}, 32'h03);
    cmp("d0_an", {28'h0, an}, 32'hE);
    wait_ft();
    cnt = 0;
    do begin tick(); cnt++; end while (frame_tick !== 1'b1 && cnt < 64);
    cmp("frame_period", cnt, 32);

    // load mid-frame: display unchanged until the wrap
    repeat (3) tick();
    load_pulse(16'h12AF, 4'h0, 4'h0);
    wait_lit(1);
    cmp("pre_xfer_d1", {24'h0, seg}, 32'h03);
    wait_ft();
    wait_lit(0); cmp("x_d0_F", {24'h0, seg}, 32'h71);
    wait_lit(1); cmp("x_d1_A", {24'h0, seg}, 32'h11);
    wait_lit(2); cmp("x_d2_2", {24'h0, seg}, 32'h25);
    wait_lit(3); cmp("x_d3_1", {24'h0, seg}, 32'h9F);

    // leading-zero suppression
    lz = 1'b1;
    load_pulse(16'h0050, 4'h0, 4'h0);
    wait_ft();
    wait_lit(0); cmp("lz_d0", {24'h0, seg}, 32'h03);
    wait_lit(1); cmp("lz_d1", {24'h0, seg}, 32'h49);
    wait_lit(2); cmp("lz_d2", {24'h0, seg}, 32'hFF);
    wait_lit(3); cmp("lz_d3", {24'h0, seg}, 32'hFF);
    load_pulse(16'h0050, 4'b1000, 4'h0);
    wait_ft();
    wait_lit(2); cmp("lzdp_d2", {24'h0, seg}, 32'h03);
    wait_lit(3); cmp("lzdp_d3", {24'h0, seg}, 32'h02);
    lz = 1'b0;

    // multiple loads in a frame, then one on the wrap edge
    wait_ft();
    load_pulse(16'h1111, 4'h0, 4'h0);
    load_pulse(16'h2222, 4'h0, 4'h0);
    repeat (29) tick();
    load_pulse(16'h3333, 4'h0, 4'h0);
    cmp("wrap_edge_ft", {31'h0, frame_tick}, 32'h1);
    wait_lit(0); cmp("last_wins", {24'h0, seg}, 32'h25);
    wait_ft();
    wait_lit(0); cmp("wrap_load_late", {24'h0, seg}, 32'h0D);

    // blanking
    load_pulse(16'h8888, 4'h0, 4'b0100);
    wait_ft();
    wait_lit(0); cmp("bl_d0", {24'h0, seg}, 32'h01);
    wait_lit(2); cmp("bl_d2_seg", {24'h0, seg}, 32'hFF);
    cmp("bl_d2_an", {28'h0, an}, 32'hB);
    wait_lit(3); cmp("bl_d3", {24'h0, seg}, 32'h01);

    // enable drop mid-slot
    wait_lit(1);
    repeat (2) tick();
    en = 1'b0;
    tick();
    cmp("dis_seg", {24'h0, seg}, 32'hFF);
    cmp("dis_an", {28'h0, an}, 32'hF);
    repeat (20) tick();
    cmp("dis_idx_hold", {30'h0, digit_idx}, 32'h1);
    en = 1'b1;
    tick();
    cmp("resume_an", {28'h0, an}, 32'hD);
    cmp("resume_seg", {24'h0, seg}, 32'h01);

    // reset mid-frame
    wait_lit(2);
    rst_n = 1'b0;
    #1;
    cmp("mrst_seg", {24'h0, seg}, 32'hFF);
    cmp("mrst_an", {28'h0, an}, 32'hF);
    cmp("mrst_idx", {30'h0, digit_idx}, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_lit(0);
    cmp("post_rst_idx", {30'h0, digit_idx}, 32'h0);
    cmp("post_rst_disp", {24'h0, seg}, 32'h03);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) lz = ~lz;
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      tick();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
